// File: rtl/if_id_buffer.sv
// IF/ID pipeline register. Pairs the latched IF pc with the one-cycle-late inst SRAM
// word and replays a captured copy of that word while ID is stalled.
module if_id_buffer #(
  parameter int                STALL_W  = 6,
  parameter int                PC_W     = 32,
  parameter int                INST_W   = 32,
  parameter logic [INST_W-1:0] NOP_INST = {INST_W{1'b0}}
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic [PC_W:0]      if_to_id_bus,
  input  logic [INST_W-1:0]  inst_sram_rdata,
  output logic               id_valid,
  output logic [PC_W-1:0]    id_pc,
  output logic [INST_W-1:0]  id_inst,
  output logic               id_hold
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_RUN   = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic                r_id_valid;
  logic                w_next_valid;
  logic [PC_W-1:0]     r_id_pc;
  logic [PC_W-1:0]     w_next_pc;
  logic [INST_W-1:0]   r_inst_buf;
  logic [INST_W-1:0]   w_next_buf;

  logic                w_if_ce;
  logic [PC_W-1:0]     w_if_pc;
  logic                w_id_stall;
  logic                w_unused_stall;

  assign w_if_ce        = if_to_id_bus[PC_W];
  assign w_if_pc        = if_to_id_bus[PC_W-1:0];
  assign w_id_stall     = stall[1];
  // Only the ID stall bit steers this stage; the rest of the vector is for other stages.
  assign w_unused_stall = ^{stall[STALL_W-1:2], stall[0]};

  // Next-state and next-slot logic: flush beats advance, advance beats hold.
  always_comb begin
    w_next_state = r_state;
    w_next_valid = r_id_valid;
    w_next_pc    = r_id_pc;
    w_next_buf   = r_inst_buf;
    if (flush) begin
      w_next_state = S_EMPTY;
      w_next_valid = 1'b0;
      w_next_buf   = {INST_W{1'b0}};
    end else if (!w_id_stall) begin
      w_next_pc    = w_if_pc;
      w_next_valid = w_if_ce;
      w_next_state = w_if_ce ? S_RUN : S_EMPTY;
    end else begin
      case (r_state)
        // The live word is only valid this cycle, so capture it before it moves on.
        S_RUN: begin
          w_next_buf   = inst_sram_rdata;
          w_next_state = S_HOLD;
        end
        S_HOLD:  w_next_state = S_HOLD;
        S_EMPTY: w_next_state = S_EMPTY;
        default: begin
          w_next_state = S_EMPTY;
          w_next_valid = 1'b0;
        end
      endcase
    end
  end

  // State and slot registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_EMPTY;
      r_id_valid <= 1'b0;
      r_id_pc    <= {PC_W{1'b0}};
      r_inst_buf <= {INST_W{1'b0}};
    end else begin
      r_state    <= w_next_state;
      r_id_valid <= w_next_valid;
      r_id_pc    <= w_next_pc;
      r_inst_buf <= w_next_buf;
    end
  end

  assign id_valid = r_id_valid;
  assign id_pc    = r_id_pc;
  assign id_hold  = (r_state == S_HOLD);
  assign id_inst  = !r_id_valid         ? NOP_INST :
                    (r_state == S_HOLD) ? r_inst_buf : inst_sram_rdata;

endmodule

// File: tb/tb_if_id_buffer.sv
// Directed-vector bench for if_id_buffer; driver pushes expected slot contents,
// a monitor pops and compares them at each negedge.
module tb_if_id_buffer;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [32:0] if_to_id_bus;
  logic [31:0] inst_sram_rdata;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_hold;

  if_id_buffer #(.STALL_W(6), .PC_W(32), .INST_W(32), .NOP_INST(32'h0)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .if_to_id_bus(if_to_id_bus), .inst_sram_rdata(inst_sram_rdata),
    .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst), .id_hold(id_hold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [1:0]  st;
    logic        fl;
    logic        ce;
    logic [31:0] pc;
    logic [31:0] rd;
    logic        ev;
    logic        cpc;
    logic [31:0] epc;
    logic [31:0] einst;
    logic        eh;
  } vec_t;

  typedef struct {
    int          idx;
    logic        ev;
    logic        cpc;
    logic [31:0] epc;
    logic [31:0] einst;
    logic        eh;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  localparam logic [31:0] A   = 32'hbfc0_0000;
  localparam logic [31:0] B   = 32'h8000_0000;
  localparam logic [31:0] X   = 32'hdead_beef;
  localparam logic [31:0] NOP = 32'h0000_0000;

  task automatic add(input logic r, input logic [1:0] st, input logic fl, input logic ce,
                     input logic [31:0] pc, input logic [31:0] rd, input logic ev,
                     input logic cpc, input logic [31:0] epc, input logic [31:0] einst,
                     input logic eh);
    vec_t v;
    v.rst = r; v.st = st; v.fl = fl; v.ce = ce; v.pc = pc; v.rd = rd;
    v.ev = ev; v.cpc = cpc; v.epc = epc; v.einst = einst; v.eh = eh;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, expv);
  endtask

  // Monitor: compare the DUT slot against the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("valid", e.idx, {31'b0, id_valid}, {31'b0, e.ev});
      chk("inst",  e.idx, id_inst, e.einst);
      chk("hold",  e.idx, {31'b0, id_hold}, {31'b0, e.eh});
      if (e.cpc) chk("pc", e.idx, id_pc, e.epc);
    end
  end

  initial begin
    rst = 1'b1; stall = 6'b0; flush = 1'b0;
    if_to_id_bus = 33'b0; inst_sram_rdata = X;

    // Expected columns: slot seen after this vector's inputs settle (previous edge + current rdata).
    //   rst st     fl    ce    pc         rd             ev    cpc   epc        einst          eh
    add(1'b1, 2'b00, 1'b0, 1'b0, 32'h0,     X,             1'b0, 1'b1, 32'h0,     NOP,           1'b0);
    add(1'b0, 2'b00, 1'b0, 1'b1, A,         X,             1'b0, 1'b1, 32'h0,     NOP,           1'b0);
    add(1'b0, 2'b00, 1'b0, 1'b1, A+32'd4,   32'h24080001,  1'b1, 1'b1, A,         32'h24080001,  1'b0);
    add(1'b0, 2'b11, 1'b0, 1'b1, A+32'd8,   32'h24090002,  1'b1, 1'b1, A+32'd4,   32'h24090002,  1'b0);
    add(1'b0, 2'b11, 1'b0, 1'b1, A+32'd8,   32'h240a0003,  1'b1, 1'b1, A+32'd4,   32'h24090002,  1'b1);
    add(1'b0, 2'b11, 1'b0, 1'b1, A+32'd8,   32'h240a0003,  1'b1, 1'b1, A+32'd4,   32'h24090002,  1'b1);
    add(1'b0, 2'b00, 1'b0, 1'b1, A+32'd8,   32'h240a0003,  1'b1, 1'b1, A+32'd4,   32'h24090002,  1'b1);
    add(1'b0, 2'b00, 1'b0, 1'b1, A+32'd12,  32'h240a0003,  1'b1, 1'b1, A+32'd8,   32'h240a0003,  1'b0);
    add(1'b0, 2'b11, 1'b0, 1'b1, A+32'd16,  32'h240b0004,  1'b1, 1'b1, A+32'd12,  32'h240b0004,  1'b0);
    add(1'b0, 2'b11, 1'b0, 1'b1, A+32'd16,  32'h240c0005,  1'b1, 1'b1, A+32'd12,  32'h240b0004,  1'b1);
    add(1'b0, 2'b11, 1'b1, 1'b1, A+32'd16,  32'h240c0005,  1'b1, 1'b1, A+32'd12,  32'h240b0004,  1'b1);
    add(1'b0, 2'b00, 1'b0, 1'b1, A+32'd16,  32'h240c0005,  1'b0, 1'b0, 32'h0,     NOP,           1'b0);
    add(1'b0, 2'b11, 1'b0, 1'b1, A+32'd20,  32'h240c0005,  1'b1, 1'b1, A+32'd16,  32'h240c0005,  1'b0);
    add(1'b0, 2'b11, 1'b0, 1'b1, A+32'd20,  32'h240d0006,  1'b1, 1'b1, A+32'd16,  32'h240c0005,  1'b1);
    add(1'b1, 2'b11, 1'b0, 1'b1, A+32'd20,  32'h240d0006,  1'b0, 1'b1, 32'h0,     NOP,           1'b0);
    add(1'b0, 2'b00, 1'b0, 1'b1, B,         X,             1'b0, 1'b1, 32'h0,     NOP,           1'b0);
    add(1'b0, 2'b00, 1'b0, 1'b1, B+32'd4,   32'h3c011111,  1'b1, 1'b1, B,         32'h3c011111,  1'b0);
    add(1'b0, 2'b00, 1'b0, 1'b0, B+32'd8,   32'h3c022222,  1'b1, 1'b1, B+32'd4,   32'h3c022222,  1'b0);
    add(1'b0, 2'b00, 1'b0, 1'b0, B+32'd8,   32'h3c033333,  1'b0, 1'b0, 32'h0,     NOP,           1'b0);
    add(1'b0, 2'b00, 1'b0, 1'b1, B+32'd8,   32'h3c044444,  1'b0, 1'b0, 32'h0,     NOP,           1'b0);
    add(1'b0, 2'b00, 1'b0, 1'b1, B+32'd12,  32'h3c055555,  1'b1, 1'b1, B+32'd8,   32'h3c055555,  1'b0);

    foreach (vecs[i]) begin
      exp_t e;
      @(posedge clk);
      #1;
      rst             = vecs[i].rst;
      stall           = {4'b0, vecs[i].st};
      flush           = vecs[i].fl;
      if_to_id_bus    = {vecs[i].ce, vecs[i].pc};
      inst_sram_rdata = vecs[i].rd;
      e.idx = i; e.ev = vecs[i].ev; e.cpc = vecs[i].cpc;
      e.epc = vecs[i].epc; e.einst = vecs[i].einst; e.eh = vecs[i].eh;
      exp_q.push_back(e);
    end

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
